// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared encodings and constants for the time-set controller
package clock_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_EDIT_HH = 3'd1,
      ST_EDIT_MM = 3'd2,
      ST_EDIT_SS = 3'd3,
      ST_WRITE   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      FIELD_NONE = 2'd0,
      FIELD_HH   = 2'd1,
      FIELD_MM   = 2'd2,
      FIELD_SS   = 2'd3
   } field_t;

   localparam logic [7:0] MIN_SEC_MAX      = 8'h59;
   localparam logic [7:0] DEFAULT_HOUR_MAX = 8'h23;
   localparam int         DIGIT_COUNT      = 6;

   function automatic field_t field_of(input state_t s);
      case (s)
         ST_EDIT_HH: return FIELD_HH;
         ST_EDIT_MM: return FIELD_MM;
         ST_EDIT_SS: return FIELD_SS;
         default:    return FIELD_NONE;
      endcase
   endfunction

   function automatic logic is_edit(input state_t s);
      return (s == ST_EDIT_HH) || (s == ST_EDIT_MM) || (s == ST_EDIT_SS);
   endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// rtl/time_set_controller_if.sv - button/tick/counter-chain signal bundle for the time-set controller
interface time_set_controller_if;
   logic        i_tick_1hz;
   logic        i_tick_2hz;
   logic        i_btn_mode;
   logic        i_btn_up;
   logic        i_btn_down;
   logic [23:0] i_digits;
   logic        o_run;
   logic [5:0]  o_wr;
   logic [3:0]  o_wr_data;
   logic [1:0]  o_field;
   logic [5:0]  o_blank;

   modport master (
      output i_tick_1hz, i_tick_2hz, i_btn_mode, i_btn_up, i_btn_down, i_digits,
      input  o_run, o_wr, o_wr_data, o_field, o_blank
   );

   modport slave (
      input  i_tick_1hz, i_tick_2hz, i_btn_mode, i_btn_up, i_btn_down, i_digits,
      output o_run, o_wr, o_wr_data, o_field, o_blank
   );
endinterface

// File: rtl/time_set_controller_bcd_pair_step.sv
// rtl/time_set_controller_bcd_pair_step.sv - one-step BCD pair increment/decrement with wrap at max
module bcd_pair_step (
   input  logic [7:0] value,
   input  logic [7:0] max_val,
   input  logic       up,
   input  logic       down,
   output logic [7:0] result
);
   logic [3:0] tens;
   logic [3:0] units;

   assign tens  = value[7:4];
   assign units = value[3:0];

   // Out-of-range inputs (e.g. a corrupt snapshot) are pulled back into legal BCD.
   always_comb begin
      result = value;
      if (up && !down) begin
         if (value >= max_val)
            result = 8'h00;
         else if (units >= 4'd9)
            result = {tens + 4'd1, 4'd0};
         else
            result = {tens, units + 4'd1};
      end else if (down && !up) begin
         if (value == 8'h00)
            result = max_val;
         else if (units == 4'd0)
            result = {tens - 4'd1, 4'd9};
         else if (units > 4'd9)
            result = {tens, 4'd9};
         else
            result = {tens, units - 4'd1};
      end
   end
endmodule

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - HH:MM:SS edit sequencer; optional display blink under TIME_SET_BLINK_EN
module time_set_controller
   import clock_ctrl_pkg::*;
#(
   parameter int         TIMEOUT_S = 30,
   parameter logic [7:0] HOUR_MAX  = DEFAULT_HOUR_MAX
) (
   input logic                  i_clk,
   input logic                  i_reset_n,
   time_set_controller_if.slave bus
);
   localparam logic [7:0] TMO_RELOAD = 8'(TIMEOUT_S);

   state_t      state, state_nxt;
   logic [23:0] shadow, shadow_nxt;
   logic [7:0]  tmo_cnt, tmo_nxt;
   logic [2:0]  wr_idx, wr_idx_nxt;
   logic [5:0]  wr_q, wr_nxt;
   logic [3:0]  wr_data_q, wr_data_nxt;
   logic        run_q;
   field_t      field_q;
   logic [7:0]  hh_step, mm_step;
   logic        any_btn, one_dir;

   assign any_btn = bus.i_btn_mode | bus.i_btn_up | bus.i_btn_down;
   assign one_dir = bus.i_btn_up ^ bus.i_btn_down;

   bcd_pair_step u_hh_step (
      .value  (shadow[23:16]),
      .max_val(HOUR_MAX),
      .up     (bus.i_btn_up),
      .down   (bus.i_btn_down),
      .result (hh_step)
   );

   bcd_pair_step u_mm_step (
      .value  (shadow[15:8]),
      .max_val(MIN_SEC_MAX),
      .up     (bus.i_btn_up),
      .down   (bus.i_btn_down),
      .result (mm_step)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_RUN;
         shadow    <= '0;
         tmo_cnt   <= '0;
         wr_idx    <= '0;
         wr_q      <= '0;
         wr_data_q <= '0;
         run_q     <= 1'b1;
         field_q   <= FIELD_NONE;
      end else begin
         state     <= state_nxt;
         shadow    <= shadow_nxt;
         tmo_cnt   <= tmo_nxt;
         wr_idx    <= wr_idx_nxt;
         wr_q      <= wr_nxt;
         wr_data_q <= wr_data_nxt;
         run_q     <= (state_nxt == ST_RUN);
         field_q   <= field_of(state_nxt);
      end
   end

   always_comb begin
      state_nxt   = state;
      shadow_nxt  = shadow;
      tmo_nxt     = tmo_cnt;
      wr_idx_nxt  = wr_idx;
      wr_nxt      = '0;
      wr_data_nxt = '0;
      case (state)
         ST_RUN: begin
            if (bus.i_btn_mode) begin
               shadow_nxt = bus.i_digits;
               state_nxt  = ST_EDIT_HH;
               tmo_nxt    = TMO_RELOAD;
            end
         end
         ST_EDIT_HH, ST_EDIT_MM, ST_EDIT_SS: begin
            if (bus.i_btn_mode) begin
               case (state)
                  ST_EDIT_HH: state_nxt = ST_EDIT_MM;
                  ST_EDIT_MM: state_nxt = ST_EDIT_SS;
                  default: begin
                     // First strobe leaves together with the state change so WRITE is exactly six cycles.
                     state_nxt   = ST_WRITE;
                     wr_nxt      = 6'b000001;
                     wr_data_nxt = shadow[3:0];
                     wr_idx_nxt  = 3'd1;
                  end
               endcase
            end else if (one_dir) begin
               case (state)
                  ST_EDIT_HH: shadow_nxt[23:16] = hh_step;
                  ST_EDIT_MM: shadow_nxt[15:8]  = mm_step;
                  default:    shadow_nxt[7:0]   = 8'h00;
               endcase
            end
            if (any_btn) begin
               tmo_nxt = TMO_RELOAD;
            end else if (bus.i_tick_1hz) begin
               if (tmo_cnt <= 8'd1) begin
                  tmo_nxt   = 8'd0;
                  state_nxt = ST_RUN;
               end else begin
                  tmo_nxt = tmo_cnt - 8'd1;
               end
            end
         end
         ST_WRITE: begin
            if (wr_idx >= 3'(DIGIT_COUNT)) begin
               state_nxt  = ST_RUN;
               wr_idx_nxt = 3'd0;
            end else begin
               wr_nxt      = 6'b000001 << wr_idx;
               wr_data_nxt = shadow[{wr_idx, 2'b00} +: 4];
               wr_idx_nxt  = wr_idx + 3'd1;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign bus.o_run     = run_q;
   assign bus.o_wr      = wr_q;
   assign bus.o_wr_data = wr_data_q;
   assign bus.o_field   = field_q;

`ifdef TIME_SET_BLINK_EN
   logic       blink_q;
   logic [5:0] blank_mask;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         blink_q <= 1'b0;
      else if (!is_edit(state_nxt))
         blink_q <= 1'b0;
      else if (bus.i_tick_2hz && is_edit(state))
         blink_q <= ~blink_q;
   end

   always_comb begin
      blank_mask = '0;
      case (state)
         ST_EDIT_HH: blank_mask = 6'b110000;
         ST_EDIT_MM: blank_mask = 6'b001100;
         ST_EDIT_SS: blank_mask = 6'b000011;
         default:    blank_mask = '0;
      endcase
   end

   assign bus.o_blank = blink_q ? blank_mask : 6'b000000;
`else
   assign bus.o_blank = 6'b000000;
`endif

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - directed scoreboard bench for time_set_controller
module tb_time_set_controller;
   logic clk;
   logic rst_n;
   int   n_asserts;
   int   n_fail;
   int   n_writes;
   logic [9:0] exp_q[$];

   time_set_controller_if tsc_if ();

   time_set_controller #(
      .TIMEOUT_S(3),
      .HOUR_MAX (8'h23)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .bus      (tsc_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write-back of a shadow value: digit k strobed with its nibble, k = 0..5.
   task automatic push_writes(input logic [23:0] sh, input int count);
      for (int k = 0; k < count; k++)
         exp_q.push_back({6'(6'b000001 << k), sh[k*4 +: 4]});
   endtask

   // Called at a negedge: apply inputs across one rising edge, return at the next negedge.
   task automatic cyc(input logic m, input logic u, input logic d, input logic t1, input logic t2);
      tsc_if.i_btn_mode = m;
      tsc_if.i_btn_up   = u;
      tsc_if.i_btn_down = d;
      tsc_if.i_tick_1hz = t1;
      tsc_if.i_tick_2hz = t2;
      @(negedge clk);
      tsc_if.i_btn_mode = 1'b0;
      tsc_if.i_btn_up   = 1'b0;
      tsc_if.i_btn_down = 1'b0;
      tsc_if.i_tick_1hz = 1'b0;
      tsc_if.i_tick_2hz = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && tsc_if.o_wr !== 6'b000000) begin
         n_writes++;
         if (exp_q.size() == 0)
            check("unexpected_wr", {22'd0, tsc_if.o_wr, tsc_if.o_wr_data}, 32'd0);
         else
            check("wr_strobe_data", {22'd0, tsc_if.o_wr, tsc_if.o_wr_data}, {22'd0, exp_q.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      n_writes  = 0;
      rst_n     = 1'b0;
      tsc_if.i_btn_mode = 1'b0;
      tsc_if.i_btn_up   = 1'b0;
      tsc_if.i_btn_down = 1'b0;
      tsc_if.i_tick_1hz = 1'b0;
      tsc_if.i_tick_2hz = 1'b0;
      tsc_if.i_digits   = 24'h235958;
      @(negedge clk);
      @(negedge clk);
      check("rst_run", 32'(tsc_if.o_run), 32'd1);
      check("rst_wr", 32'(tsc_if.o_wr), 32'd0);
      check("rst_wr_data", 32'(tsc_if.o_wr_data), 32'd0);
      check("rst_field", 32'(tsc_if.o_field), 32'd0);
      check("rst_blank", 32'(tsc_if.o_blank), 32'd0);
      rst_n = 1'b1;
      idle(1);

      // Straight pass-through of 23:59:58
      cyc(1, 0, 0, 0, 0);
      check("edit_run", 32'(tsc_if.o_run), 32'd0);
      check("edit_field_hh", 32'(tsc_if.o_field), 32'd1);
      cyc(1, 0, 0, 0, 0);
      check("edit_field_mm", 32'(tsc_if.o_field), 32'd2);
      cyc(1, 0, 0, 0, 0);
      check("edit_field_ss", 32'(tsc_if.o_field), 32'd3);
      push_writes(24'h235958, 6);
      cyc(1, 0, 0, 0, 0);
      check("write_run0", 32'(tsc_if.o_run), 32'd0);
      idle(5);
      check("write_last_run", 32'(tsc_if.o_run), 32'd0);
      idle(1);
      check("post_write_run", 32'(tsc_if.o_run), 32'd1);
      check("post_write_wr", 32'(tsc_if.o_wr), 32'd0);
      check("post_write_field", 32'(tsc_if.o_field), 32'd0);
      check("write_count1", 32'(n_writes), 32'd6);

      // Hour/minute wraps, seconds clear: 23:00:47 -> 22:59:00
      tsc_if.i_digits = 24'h230047;
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      push_writes(24'h225900, 6);
      cyc(1, 0, 0, 0, 0);
      idle(7);
      check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

      // BCD carries and up+down ignored: 19:09:12 -> 20:10:12
      tsc_if.i_digits = 24'h190912;
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      push_writes(24'h201012, 6);
      cyc(1, 0, 0, 0, 0);
      idle(7);
      check("carry_q_empty", 32'(exp_q.size()), 32'd0);

      // Mode beats up; up+down in minutes is a no-op
      tsc_if.i_digits = 24'h081530;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      check("mode_up_field", 32'(tsc_if.o_field), 32'd2);
      cyc(0, 1, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      push_writes(24'h081530, 6);
      cyc(1, 0, 0, 0, 0);
      idle(7);
      check("prio_q_empty", 32'(exp_q.size()), 32'd0);

      // Timeout after three idle ticks, no writes
      n_writes = 0;
      tsc_if.i_digits = 24'h111111;
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      check("tmo_still_edit", 32'(tsc_if.o_field), 32'd1);
      cyc(0, 0, 0, 1, 0);
      check("tmo_run", 32'(tsc_if.o_run), 32'd1);
      check("tmo_field", 32'(tsc_if.o_field), 32'd0);
      idle(2);
      check("tmo_no_writes", 32'(n_writes), 32'd0);

      // Button on a tick cycle reloads the count
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      check("reload_still_edit", 32'(tsc_if.o_field), 32'd1);
      cyc(0, 0, 0, 1, 0);
      check("reload_tmo_run", 32'(tsc_if.o_run), 32'd1);
      idle(2);
      check("reload_no_writes", 32'(n_writes), 32'd0);

`ifdef TIME_SET_BLINK_EN
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check("blink_initial", 32'(tsc_if.o_blank), 32'h00);
      cyc(0, 0, 0, 0, 1);
      check("blink_on", 32'(tsc_if.o_blank), 32'h0c);
      cyc(0, 0, 0, 0, 1);
      check("blink_off", 32'(tsc_if.o_blank), 32'h00);
      cyc(0, 0, 0, 0, 1);
      check("blink_on2", 32'(tsc_if.o_blank), 32'h0c);
      idle(1);
      check("blink_hold", 32'(tsc_if.o_blank), 32'h0c);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      check("blink_exit_run", 32'(tsc_if.o_run), 32'd1);
      check("blink_exit_blank", 32'(tsc_if.o_blank), 32'h00);
`else
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      check("noblink_blank", 32'(tsc_if.o_blank), 32'h00);
      cyc(0, 0, 0, 0, 1);
      check("noblink_blank2", 32'(tsc_if.o_blank), 32'h00);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      check("noblink_exit_run", 32'(tsc_if.o_run), 32'd1);
`endif

      // Reset during the third write cycle
      n_writes = 0;
      tsc_if.i_digits = 24'h123456;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      push_writes(24'h123456, 3);
      cyc(1, 0, 0, 0, 0);
      idle(2);
      check("midwr_third", 32'(tsc_if.o_wr), 32'h04);
      #2;
      rst_n = 1'b0;
      #1;
      check("midwr_async_wr", 32'(tsc_if.o_wr), 32'd0);
      check("midwr_async_run", 32'(tsc_if.o_run), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      check("midwr_run", 32'(tsc_if.o_run), 32'd1);
      check("midwr_field", 32'(tsc_if.o_field), 32'd0);
      check("midwr_wr_idle", 32'(tsc_if.o_wr), 32'd0);
      check("midwr_count", 32'(n_writes), 32'd3);
      check("midwr_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequencer for the six-digit HH:MM:SS chain of decade counters on the clock board.
- In RUN it enables the counters.
- On a mode press it freezes them, snapshots the displayed time into shadow registers and lets the user edit hours, then minutes, then seconds with up/down buttons.
- On the final mode press it writes the shadow digits back into the counters through their parallel-load (write strobe + 4-bit data) ports, one digit per clock.

Parameters:
- TIMEOUT_S, 30, number of i_tick_1hz pulses with no button activity before an edit is abandoned (range 1..255).
- HOUR_MAX, 23, highest legal hour value (BCD pair), used for hour wrap.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_tick_1hz  in  1  one-cycle pulse, once per second
- i_tick_2hz  in  1  one-cycle pulse, twice per second (blink timing)
- i_btn_mode  in  1  debounced one-cycle press pulse
- i_btn_up  in  1  debounced one-cycle press pulse
- i_btn_down  in  1  debounced one-cycle press pulse
- i_digits  in  24  current counter values, BCD, [3:0]=sec units ... [23:20]=hour tens
- o_run  out  1  counter chain enable gate; 1 only in RUN
- o_wr  out  6  one-hot per-digit write strobe, bit k = digit k
- o_wr_data  out  4  BCD value for the strobed digit
- o_field  out  2  field being edited: 0 none, 1 HH, 2 MM, 3 SS
- o_blank  out  6  per-digit blank mask for the display driver

Behaviour:
- Reset (async assert, sync release): state RUN. o_run=1, o_wr=0, o_wr_data=0, o_field=0, o_blank=0, shadow=0, timeout count=0.
- States: RUN, EDIT_HH, EDIT_MM, EDIT_SS, WRITE.
- RUN + mode: capture i_digits into shadow the same cycle. Next cycle: EDIT_HH, o_run=0, o_field=1.
- EDIT_HH + mode -> EDIT_MM. EDIT_MM + mode -> EDIT_SS. EDIT_SS + mode -> WRITE.
- Up/down in EDIT_HH/EDIT_MM: BCD-pair increment/decrement of the field.
  - Up at max wraps to 00; down at 00 wraps to max (HOUR_MAX for hours, 59 for minutes).
  - Units carry/borrow through 9/0 in BCD. Never produce a non-BCD nibble.
- Up or down in EDIT_SS clears seconds to 00.
- Priority within one cycle: mode beats up/down. Up and down together are ignored (treated as activity for timeout).
- Timeout:
  - Counter reloads to TIMEOUT_S on entry to EDIT_HH and on any button pulse.
  - Decrements on i_tick_1hz; a button in the same cycle wins (reload).
  - On reaching 0 in any EDIT state: return to RUN, no writes, counters resume from their frozen values.
- WRITE:
  - Six consecutive cycles, digit 0 to 5. o_wr=1<<k, o_wr_data=shadow digit k, registered outputs.
  - Buttons are ignored.
  - Cycle after digit 5: RUN, o_run=1, o_wr=0.
- o_run is 0 from EDIT_HH through the last WRITE cycle inclusive.
- Reset mid-WRITE: writes stop immediately. Digits already loaded keep their new values.

Optional Feature:
- Macro: TIME_SET_BLINK_EN.
- Defined: a blink flop toggles on each i_tick_2hz while in an EDIT state and clears on leaving it. When the flop is 1, o_blank has ones on the two digits of the current field (HH=bits 5:4, MM=3:2, SS=1:0). Otherwise o_blank=0.
- Undefined: o_blank tied to 0 and no blink flop is built; i_tick_2hz is unused.

Decomposition:
- Package clock_ctrl_pkg: state encoding (RUN..WRITE), field codes (0..3), MIN_SEC_MAX=8'h59, default HOUR_MAX=8'h23, DIGIT_COUNT=6.
- Sub-module bcd_pair_step: combinational up/down/wrap of an 8-bit BCD pair given a max value. Instantiated for the hours and minutes fields.

Test Plan:
- Reset, i_digits=24'h235958, mode -> next cycle o_run=0, o_field=1; mode×3 -> six write cycles o_wr 000001..100000 with data 8,5,9,5,3,2; then o_run=1.
- EDIT_HH from 23, up once -> hours 00; down once -> 23. EDIT_MM from 00, down -> 59. Write-back shows hour tens/units and minute tens/units as loaded.
- EDIT_SS with seconds 47, up -> write phase loads seconds digits 0,0.
- TIMEOUT_S=3: enter edit, no buttons, three 1 Hz ticks -> RUN, o_wr never asserted, o_run=1. Button on the tick cycle -> count reloads to 3.
- Mode+up same cycle in EDIT_HH -> advances to EDIT_MM, hours unchanged. Up+down together -> no change.
- Reset_n low during third WRITE cycle -> o_wr=0 asynchronously, state RUN, o_run=1 after release.
- With TIME_SET_BLINK_EN: in EDIT_MM, o_blank toggles 000000/001100 on each 2 Hz tick. Without the macro: o_blank stays 0.
